// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module mips_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             cancel,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_FIX
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic                 r_is_div;
   logic                 r_sa;
   logic                 r_sb;
   logic                 r_bzero;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_done;

   logic                 w_launch;
   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;

   logic [WIDTH:0]       w_mul_sum;
   logic [2*WIDTH-1:0]   w_mul_acc;
   logic [WIDTH:0]       w_rem_sh;
   logic [WIDTH:0]       w_diff;
   logic                 w_ge;
   logic [2*WIDTH-1:0]   w_div_acc;

   logic                 w_neg_res;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quot;
   logic [WIDTH-1:0]     w_rem;

   assign w_launch = start && !cancel;
   assign w_a_neg  = op[0] && srca[WIDTH-1];
   assign w_b_neg  = op[0] && srcb[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -srca : srca;
   assign w_b_mag  = w_b_neg ? -srcb : srcb;

   // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};
   assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide: upper half is the partial remainder, lower half collects quotient bits.
   assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
   assign w_diff    = w_rem_sh - {1'b0, r_b};
   assign w_ge      = ~w_diff[WIDTH];
   assign w_div_acc = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_ge};

   assign w_neg_res = r_sa ^ r_sb;
   assign w_prod    = w_neg_res ? -r_acc : r_acc;
   assign w_quot    = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   // With a zero divisor the remainder half ends up holding |srca|, so re-signing restores srca.
   assign w_rem     = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_launch) w_state_next = S_PREP;
         S_PREP: w_state_next = S_CALC;
         S_CALC: if (r_cnt == LAST) w_state_next = S_FIX;
         S_FIX:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      if (cancel && r_state != S_IDLE) begin
         w_state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_is_div <= 1'b0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_bzero  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (we_hi) r_hi <= wdata;
               if (we_lo) r_lo <= wdata;
               if (w_launch) begin
                  r_is_div <= op[1];
                  r_sa     <= w_a_neg;
                  r_sb     <= w_b_neg;
                  r_bzero  <= (srcb == '0);
                  r_a      <= w_a_mag;
                  r_b      <= w_b_mag;
               end
            end
            S_PREP: begin
               r_acc <= '0;
               r_cnt <= '0;
            end
            S_CALC: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_is_div) begin
                  r_acc <= w_div_acc;
                  r_a   <= r_a << 1;
               end else begin
                  r_acc <= w_mul_acc;
                  r_b   <= r_b >> 1;
               end
            end
            S_FIX: begin
               if (!cancel) begin
                  r_done <= 1'b1;
                  if (r_is_div) begin
                     r_hi <= w_rem;
                     r_lo <= r_bzero ? '1 : w_quot;
                  end else begin
                     r_hi <= w_prod[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod[WIDTH-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv at WIDTH=32 and WIDTH=8: the driver queues
// expected {hi,lo} and completion cycle, per-instance monitors check on done.
module tb_mips_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, cancel = 1'b0, we_hi = 1'b0, we_lo = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] srca = '0, srcb = '0, wdata = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   logic        s8_start = 1'b0;
   logic [1:0]  s8_op = 2'b00;
   logic [7:0]  s8_srca = '0, s8_srcb = '0;
   logic        s8_busy, s8_done;
   logic [7:0]  s8_hi, s8_lo;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [63:0] exp_q[$];
   int          cyc_q[$];
   string       name_q[$];
   logic [15:0] exp8_q[$];
   int          cyc8_q[$];
   string       name8_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mips_muldiv #(.WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .cancel(cancel), .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   mips_muldiv #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(s8_start), .op(s8_op), .srca(s8_srca), .srcb(s8_srcb),
      .cancel(1'b0), .we_hi(1'b0), .we_lo(1'b0), .wdata(8'h00),
      .busy(s8_busy), .done(s8_done), .hi(s8_hi), .lo(s8_lo)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done32", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            int          c;
            string       nm;
            e  = exp_q.pop_front();
            c  = cyc_q.pop_front();
            nm = name_q.pop_front();
            check(nm, {hi, lo}, e);
            check({nm, "_cycle"}, 64'(cyc), 64'(c));
            $display("[TB] %s hi=0x%08h lo=0x%08h at cycle %0d", nm, hi, lo, cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (s8_done === 1'b1) begin
         if (exp8_q.size() == 0) begin
            check("unexpected_done8", 64'd1, 64'd0);
         end else begin
            logic [15:0] e;
            int          c;
            string       nm;
            e  = exp8_q.pop_front();
            c  = cyc8_q.pop_front();
            nm = name8_q.pop_front();
            check(nm, {48'd0, s8_hi, s8_lo}, {48'd0, e});
            check({nm, "_cycle"}, 64'(cyc), 64'(c));
            $display("[TB] %s hi=0x%02h lo=0x%02h at cycle %0d", nm, s8_hi, s8_lo, cyc);
         end
      end
   end

   // Called at a negedge; returns at the negedge where busy has fallen (the done cycle).
   task automatic wait_idle(input string nm);
      int i;
      for (i = 0; i < 200 && (busy || s8_busy); i++) @(negedge clk);
      if (busy || s8_busy) check({nm, "_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic issue32(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
      start = 1'b1; op = o; srca = a; srcb = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + 34);
      name_q.push_back(nm);
      check({nm, "_busy"}, 64'(busy), 64'd1);
      wait_idle(nm);
   endtask

   task automatic issue8(input string nm, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp);
      s8_start = 1'b1; s8_op = o; s8_srca = a; s8_srcb = b;
      @(posedge clk);
      @(negedge clk);
      s8_start = 1'b0;
      exp8_q.push_back(exp);
      cyc8_q.push_back(cyc + 10);
      name8_q.push_back(nm);
      wait_idle(nm);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done, n_busy;
      repeat (3) @(negedge clk);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy_done", {62'd0, busy, done}, 64'd0);
      check("rst8_state", {46'd0, s8_busy, s8_done, s8_hi, s8_lo}, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Back-to-back chain: each issue starts in the previous one's done cycle.
      issue32("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      issue32("mult_m3x5",  2'b01, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1);
      issue32("mult_7xm1",  2'b01, 32'd7,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9);
      issue32("multu_shift",2'b00, 32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780);
      issue32("div_m7d2",   2'b11, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
      issue32("div_7dm2",   2'b11, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
      issue32("divu_100d7", 2'b10, 32'd100,       32'd7,         64'h0000_0002_0000_000E);
      issue32("div_minm1",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      issue32("divu_5d0",   2'b10, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF);
      issue32("div_m7d0",   2'b11, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF);
      @(negedge clk);
      check("post_done_idle", {62'd0, busy, done}, 64'd0);

      // Write and start in the same idle cycle: the write lands, the op later overwrites.
      start = 1'b1; op = 2'b00; srca = 32'd6; srcb = 32'd7; we_hi = 1'b1; wdata = 32'h77;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; we_hi = 1'b0;
      check("start_with_mthi", 64'(hi), 64'h77);
      exp_q.push_back(64'd42);
      cyc_q.push_back(cyc + 34);
      name_q.push_back("multu_6x7_mthi");
      wait_idle("multu_6x7_mthi");
      @(negedge clk);

      we_hi = 1'b1; wdata = 32'hA;
      @(negedge clk);
      we_hi = 1'b0; we_lo = 1'b1; wdata = 32'hB;
      check("mthi", 64'(hi), 64'hA);
      @(negedge clk);
      we_lo = 1'b0;
      check("mtlo", 64'(lo), 64'hB);

      // Cancel at t0+10, with an ignored start and MTHI at t0+4.
      start = 1'b1; op = 2'b10; srca = 32'd100; srcb = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; op = 2'b00; srca = 32'd3; srcb = 32'd3; we_hi = 1'b1; wdata = 32'h55;
      @(negedge clk);
      start = 1'b0; we_hi = 1'b0;
      check("mthi_while_busy", 64'(hi), 64'hA);
      repeat (5) @(negedge clk);
      check("busy_before_cancel", 64'(busy), 64'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel_busy", 64'(busy), 64'd0);
      check("cancel_hilo", {hi, lo}, 64'h0000_000A_0000_000B);
      n_done = 0; n_busy = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n_done++;
         if (busy) n_busy++;
      end
      check("cancel_no_done", 64'(n_done), 64'd0);
      check("cancel_stays_idle", 64'(n_busy), 64'd0);

      // Cancel together with start in idle must not launch.
      start = 1'b1; cancel = 1'b1; op = 2'b00;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      check("cancel_start_idle", 64'(busy), 64'd0);

      // Reset at t0+20 of a MULT.
      start = 1'b1; op = 2'b01; srca = 32'd7; srcb = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("busy_before_rst", 64'(busy), 64'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midop_rst_hilo", {hi, lo}, 64'd0);
      check("midop_rst_busy", {62'd0, busy, done}, 64'd0);
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      check("rst_no_done", 64'(n_done), 64'd0);

      issue8("w8_mult_80x80", 2'b01, 8'h80, 8'h80, 16'h4000);
      issue8("w8_multu_ff",   2'b00, 8'hFF, 8'hFF, 16'hFE01);
      issue8("w8_div_minm1",  2'b11, 8'h80, 8'hFF, 16'h0080);
      issue8("w8_div_m7d2",   2'b11, 8'hF9, 8'h02, 16'hFFFD);
      issue8("w8_divu_d0",    2'b10, 8'h5A, 8'h00, 16'h5AFF);
      repeat (3) @(negedge clk);

      check("queue32_drained", 64'(exp_q.size()), 64'd0);
      check("queue8_drained", 64'(exp8_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
